// File: rtl/apu_timing_pkg.sv
// apu_timing_pkg
//   Shared timing constants for the sound subsystem's single-clock strobe
//   generator (ac97_bitclk = 12.288 MHz).
//   - PRESCALE          : bitclk cycles per 512 Hz frame-sequencer step
//   - F12_NUM / F12_DEN : ch1/2 fractional divider (exact 131072 Hz)
//   - F3_NUM  / F3_DEN  : ch3 fractional divider (exact 65536 Hz)
//   - F12_DIV / F3_DIV  : integer divides used when APU_EXACT_FREQ_EN is undefined
//   - *_MASK            : per-step decode, bit S set = strobe fires when step S executes
package apu_timing_pkg;

  localparam int unsigned PRESCALE = 24000;
  localparam int unsigned F12_NUM  = 4;
  localparam int unsigned F12_DEN  = 375;
  localparam int unsigned F3_NUM   = 2;
  localparam int unsigned F3_DEN   = 375;
  localparam int unsigned F12_DIV  = 94;
  localparam int unsigned F3_DIV   = 188;

  localparam logic [7:0] LENGTH_MASK = 8'b0101_0101;
  localparam logic [7:0] SWEEP_MASK  = 8'b0100_0100;
  localparam logic [7:0] ENV_MASK    = 8'b1000_0000;

  typedef logic [2:0] frame_step_t;

endpackage

// File: rtl/apu_frac_divider.sv
// apu_frac_divider
//   Produces a one-cycle tick at an average rate of clk * NUM / DEN.
//   Configuration macro: APU_EXACT_FREQ_EN
//     defined   : fractional accumulator, acc += NUM, subtract DEN on overflow
//     undefined : plain divide-by-DIV counter, tick on the DIV-1 -> 0 wrap
//   Ports:
//     clk   in  : clock
//     rst_n in  : asynchronous active-low reset
//     clear in  : synchronous clear; accumulator -> 0 and tick -> 0 on next edge
//     tick  out : registered one-cycle strobe
module apu_frac_divider #(
  parameter int unsigned NUM = 1,
  parameter int unsigned DEN = 2,
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

`ifdef APU_EXACT_FREQ_EN
  localparam bit EXACT = 1'b1;
`else
  localparam bit EXACT = 1'b0;
`endif

  // An integer divide-by-DIV is the same accumulator with increment 1 and
  // modulus DIV, so both builds share one datapath.
  localparam int unsigned STEP    = EXACT ? NUM : 1;
  localparam int unsigned MODULUS = EXACT ? DEN : DIV;
  localparam int unsigned AW      = $clog2(MODULUS + STEP);
  localparam int unsigned SW      = AW + 1;

  logic [AW-1:0] acc_q, acc_d;
  logic          tick_q, tick_d;
  logic [SW-1:0] sum;

  // sum is one bit wider than acc so acc + STEP can never wrap before compare.
  always_comb begin
    sum    = {1'b0, acc_q} + SW'(STEP);
    acc_d  = '0;
    tick_d = 1'b0;
    if (!clear) begin
      if (sum >= SW'(MODULUS)) begin
        acc_d  = AW'(sum - SW'(MODULUS));
        tick_d = 1'b1;
      end else begin
        acc_d  = AW'(sum);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer
//   Single-clock timing controller for the sound channels. Replaces derived
//   clocks with one-cycle enable strobes in the ac97_bitclk domain.
//   Configuration macro: APU_EXACT_FREQ_EN (selects exact fractional freq
//   strobes in apu_frac_divider; the frame-sequencer path is unaffected).
//   Ports:
//     ac97_bitclk         in  : the only clock
//     reset_b             in  : asynchronous active-low reset
//     master_sound_enable in  : NR52 bit 7, level
//     seq_restart         in  : one-cycle synchronous restart
//     frame_step          out : index of the next step to execute
//     length_tick         out : 256 Hz strobe (steps 0,2,4,6)
//     sweep_tick          out : 128 Hz strobe (steps 2,6)
//     env_tick            out : 64 Hz strobe (step 7)
//     ch12_freq_tick      out : 131072 Hz strobe
//     ch3_freq_tick       out : 65536 Hz strobe
module apu_frame_sequencer
  import apu_timing_pkg::*;
#(
  parameter int unsigned PRESCALE = apu_timing_pkg::PRESCALE,
  parameter int unsigned F12_NUM  = apu_timing_pkg::F12_NUM,
  parameter int unsigned F12_DEN  = apu_timing_pkg::F12_DEN,
  parameter int unsigned F3_NUM   = apu_timing_pkg::F3_NUM,
  parameter int unsigned F3_DEN   = apu_timing_pkg::F3_DEN,
  parameter int unsigned F12_DIV  = apu_timing_pkg::F12_DIV,
  parameter int unsigned F3_DIV   = apu_timing_pkg::F3_DIV
) (
  input  logic        ac97_bitclk,
  input  logic        reset_b,
  input  logic        master_sound_enable,
  input  logic        seq_restart,
  output logic [2:0]  frame_step,
  output logic        length_tick,
  output logic        sweep_tick,
  output logic        env_tick,
  output logic        ch12_freq_tick,
  output logic        ch3_freq_tick
);

  localparam int unsigned   PW            = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

  logic          running;
  logic          wrap;
  logic          div_clear;
  logic [PW-1:0] presc_q, presc_d;
  frame_step_t   step_q, step_d;
  logic          length_q, length_d;
  logic          sweep_q, sweep_d;
  logic          env_q, env_d;

  // Anything other than "running" collapses every counter to zero, so a
  // restart that lands on a wrap simply loses that wrap's strobes.
  always_comb begin
    running   = master_sound_enable & ~seq_restart;
    wrap      = running && (presc_q == PRESCALE_LAST);
    div_clear = ~running;
    presc_d   = '0;
    step_d    = '0;
    length_d  = 1'b0;
    sweep_d   = 1'b0;
    env_d     = 1'b0;
    if (running) begin
      if (wrap) begin
        step_d   = step_q + 3'd1;
        length_d = LENGTH_MASK[step_q];
        sweep_d  = SWEEP_MASK[step_q];
        env_d    = ENV_MASK[step_q];
      end else begin
        presc_d  = presc_q + 1'b1;
        step_d   = step_q;
      end
    end
  end

  always_ff @(posedge ac97_bitclk or negedge reset_b) begin
    if (!reset_b) begin
      presc_q  <= '0;
      step_q   <= '0;
      length_q <= 1'b0;
      sweep_q  <= 1'b0;
      env_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      step_q   <= step_d;
      length_q <= length_d;
      sweep_q  <= sweep_d;
      env_q    <= env_d;
    end
  end

  assign frame_step  = step_q;
  assign length_tick = length_q;
  assign sweep_tick  = sweep_q;
  assign env_tick    = env_q;

  apu_frac_divider #(
    .NUM (F12_NUM),
    .DEN (F12_DEN),
    .DIV (F12_DIV)
  ) u_ch12_div (
    .clk   (ac97_bitclk),
    .rst_n (reset_b),
    .clear (div_clear),
    .tick  (ch12_freq_tick)
  );

  apu_frac_divider #(
    .NUM (F3_NUM),
    .DEN (F3_DEN),
    .DIV (F3_DIV)
  ) u_ch3_div (
    .clk   (ac97_bitclk),
    .rst_n (reset_b),
    .clear (div_clear),
    .tick  (ch3_freq_tick)
  );

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// tb_apu_frame_sequencer
//   Directed bench for apu_frame_sequencer with a shortened prescaler so that
//   whole 8-step frames fit in a short run. Expected values are hand-derived
//   from the step masks and divider ratios; APU_EXACT_FREQ_EN selects which
//   freq-strobe expectations apply.
module tb_apu_frame_sequencer;

  localparam int P = 240;

`ifdef APU_EXACT_FREQ_EN
  localparam int G12_LO = 93;
  localparam int G3_LO  = 187;
  localparam int C12_AT_3750 = 40;
  localparam int C3_AT_3750  = 20;
`else
  localparam int G12_LO = 94;
  localparam int G3_LO  = 188;
  localparam int C12_AT_3750 = 39;
  localparam int C3_AT_3750  = 19;
`endif
  localparam int G12_HI = 94;
  localparam int G3_HI  = 188;

  // clock / reset
  logic clk = 1'b0;
  logic reset_b;
  logic en;
  logic rst_pulse;
  always #5 clk = ~clk;

  logic [2:0] frame_step;
  logic length_tick, sweep_tick, env_tick, ch12_freq_tick, ch3_freq_tick;

  apu_frame_sequencer #(.PRESCALE(P)) dut (
    .ac97_bitclk         (clk),
    .reset_b             (reset_b),
    .master_sound_enable (en),
    .seq_restart         (rst_pulse),
    .frame_step          (frame_step),
    .length_tick         (length_tick),
    .sweep_tick          (sweep_tick),
    .env_tick            (env_tick),
    .ch12_freq_tick      (ch12_freq_tick),
    .ch3_freq_tick       (ch3_freq_tick)
  );

  // scoreboard state
  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  int c_len, c_sw, c_env, c_ls, c_c12, c_c3;
  int first_len, first_sw, first_env, first_c12;
  int last_c12, last_c3, bad_gap12, bad_gap3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_tally();
    cyc = 0;
    c_len = 0; c_sw = 0; c_env = 0; c_ls = 0; c_c12 = 0; c_c3 = 0;
    first_len = 0; first_sw = 0; first_env = 0; first_c12 = 0;
    last_c12 = 0; last_c3 = 0; bad_gap12 = 0; bad_gap3 = 0;
  endtask

  // One clock: sample #1 after the edge and tally strobes. cyc counts edges
  // since the first running edge, so a tick on edge E+k shows as cyc k+1.
  task automatic step_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (length_tick) begin
      c_len++;
      if (first_len == 0) first_len = cyc;
    end
    if (sweep_tick) begin
      c_sw++;
      if (first_sw == 0) first_sw = cyc;
    end
    if (env_tick) begin
      c_env++;
      if (first_env == 0) first_env = cyc;
    end
    if (length_tick && sweep_tick) c_ls++;
    if (ch12_freq_tick) begin
      if ((cyc - last_c12) < G12_LO || (cyc - last_c12) > G12_HI) bad_gap12++;
      if (first_c12 == 0) first_c12 = cyc;
      last_c12 = cyc;
      c_c12++;
    end
    if (ch3_freq_tick) begin
      if ((cyc - last_c3) < G3_LO || (cyc - last_c3) > G3_HI) bad_gap3++;
      last_c3 = cyc;
      c_c3++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  // Disable for one edge to clear everything, then enable; next edge is E.
  task automatic start_fresh();
    en = 1'b0;
    rst_pulse = 1'b0;
    step_cycle();
    en = 1'b1;
    clear_tally();
  endtask

  task automatic check_full_frame(input string pfx);
    check({pfx, "_first_len"}, first_len, P);
    check({pfx, "_first_sweep"}, first_sw, 3 * P);
    check({pfx, "_first_env"}, first_env, 8 * P);
    check({pfx, "_len_count"}, c_len, 4);
    check({pfx, "_sweep_count"}, c_sw, 2);
    check({pfx, "_env_count"}, c_env, 1);
    check({pfx, "_len_sweep_coincide"}, c_ls, 2);
    check({pfx, "_frame_step_end"}, frame_step, 0);
    check({pfx, "_c12_count"}, c_c12, 20);
    check({pfx, "_c3_count"}, c_c3, 10);
  endtask

  initial begin
    reset_b = 1'b0;
    en = 1'b0;
    rst_pulse = 1'b0;
    clear_tally();

    // reset state
    #22;
    check("reset_outputs",
          {24'd0, frame_step, length_tick, sweep_tick, env_tick, ch12_freq_tick, ch3_freq_tick}, 0);
    @(negedge clk);
    reset_b = 1'b1;

    // full 8-step frame from enable
    start_fresh();
    run(8 * P);
    check_full_frame("frame");
    check("frame_gap12", bad_gap12, 0);
    check("frame_gap3", bad_gap3, 0);

    // frequency strobes
    start_fresh();
    run(3750);
    check("freq_c12_at_3750", c_c12, C12_AT_3750);
    check("freq_c3_at_3750", c_c3, C3_AT_3750);
    check("freq_first_c12", first_c12, 94);
    run(9400 - 3750);
    check("freq_c12_9400", c_c12, 100);
    check("freq_c3_9400", c_c3, 50);
    check("freq_gap12", bad_gap12, 0);
    check("freq_gap3", bad_gap3, 0);

    // restart on the step-2 wrap
    start_fresh();
    run(3 * P - 1);
    check("rst_pre_len_count", c_len, 1);
    check("rst_pre_step", frame_step, 2);
    rst_pulse = 1'b1;
    step_cycle();
    rst_pulse = 1'b0;
    check("rst_wrap_len", length_tick, 0);
    check("rst_wrap_sweep", sweep_tick, 0);
    check("rst_wrap_step", frame_step, 0);
    clear_tally();
    run(P);
    check("rst_next_first_len", first_len, P);
    check("rst_next_sweep_count", c_sw, 0);
    check("rst_next_step", frame_step, 1);

    // enable dropped mid step 5, then re-enabled
    start_fresh();
    run(5 * P + P / 2);
    check("drop_pre_step", frame_step, 5);
    en = 1'b0;
    clear_tally();
    run(50);
    check("drop_no_strobes", c_len + c_sw + c_env + c_c12 + c_c3, 0);
    check("drop_step", frame_step, 0);
    en = 1'b1;
    clear_tally();
    run(P);
    check("reen_first_len", first_len, P);
    check("reen_len_count", c_len, 1);
    check("reen_step", frame_step, 1);

    // asynchronous reset between edges
    start_fresh();
    run(P);
    check("areset_pre_len", length_tick, 1);
    check("areset_pre_step", frame_step, 1);
    #3;
    reset_b = 1'b0;
    #1;
    check("areset_immediate",
          {24'd0, frame_step, length_tick, sweep_tick, env_tick, ch12_freq_tick, ch3_freq_tick}, 0);
    step_cycle();
    check("areset_held",
          {24'd0, frame_step, length_tick, sweep_tick, env_tick, ch12_freq_tick, ch3_freq_tick}, 0);
    @(negedge clk);
    reset_b = 1'b1;
    clear_tally();
    run(8 * P);
    check_full_frame("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/apu_frame_sequencer.md
# apu_frame_sequencer

Timing controller for the sound subsystem. It replaces the chain of derived clocks with single-cycle enable strobes in the `ac97_bitclk` domain, so every channel runs on one clock. It produces:
- the 512 Hz Game Boy frame sequencer (length, sweep and envelope ticks);
- the channel 1/2 (131072 Hz) frequency-timer strobe;
- the channel 3 (65536 Hz) frequency-timer strobe.

It sits between the sound register file (enable/restart) and the channel generators.

## Interface
Parameters:
- `PRESCALE`, 24000: `ac97_bitclk` cycles per frame-sequencer step (12.288 MHz / 512 Hz).
- `F12_NUM`, 4: ch1/2 accumulator increment.
- `F12_DEN`, 375: ch1/2 accumulator modulus. 12.288 MHz × 4/375 = 131072 Hz exactly.
- `F3_NUM`, 2: ch3 accumulator increment.
- `F3_DEN`, 375: ch3 accumulator modulus. Gives 65536 Hz exactly.
- `F12_DIV`, 94: ch1/2 integer divide, used only with the macro off.
- `F3_DIV`, 188: ch3 integer divide, used only with the macro off.

Ports:
- `ac97_bitclk  in  1`: the only clock.
- `reset_b  in  1`: reset, asynchronous, active-low.
- `master_sound_enable  in  1`: NR52 bit 7, level.
- `seq_restart  in  1`: single-cycle synchronous restart pulse.
- `frame_step  out  3`: index of the next step to execute.
- `length_tick  out  1`: one-cycle strobe, 256 Hz.
- `sweep_tick  out  1`: one-cycle strobe, 128 Hz.
- `env_tick  out  1`: one-cycle strobe, 64 Hz.
- `ch12_freq_tick  out  1`: one-cycle strobe, 131072 Hz.
- `ch3_freq_tick  out  1`: one-cycle strobe, 65536 Hz.

## Operation
- Internal state:
  - prescaler `0..PRESCALE-1`;
  - 3-bit step counter;
  - two fractional accumulators (or integer counters with the macro off).
- Running condition: `master_sound_enable` is 1 and `seq_restart` is 0.
- While not running, on the next edge:
  - prescaler, step and accumulators clear to 0;
  - all tick outputs are 0.
- Frame wrap: occurs when running with prescaler == `PRESCALE-1`. On that edge:
  - prescaler ← 0;
  - the current step S executes, then step ← S+1 (mod 8; 7 wraps to 0).
- Step execution (registered strobes):
  - `length_tick` = 1 if S is 0, 2, 4 or 6;
  - `sweep_tick` = 1 if S is 2 or 6;
  - `env_tick` = 1 if S is 7.
- Fractional divider, evaluated each running cycle with sum = acc + NUM:
  - if sum ≥ DEN: acc ← sum − DEN and tick ← 1;
  - otherwise: acc ← sum and tick ← 0.
- Accumulator width: ceil(log2(DEN+NUM)) bits. The comparison is unsigned and must not overflow.
- `frame_step` presents the step counter value.

## Timing
- Reset values: all outputs 0, `frame_step` 0, all internal counters 0.
- All strobes are registered and high for exactly one `ac97_bitclk` cycle.
- Let E be the first edge at which the block is running:
  - first `length_tick` is high in the cycle after edge E+`PRESCALE`−1 (24000 cycles after E);
  - `sweep_tick` first fires on the 3rd frame wrap;
  - `env_tick` first fires on the 8th frame wrap.
- `length_tick` and `sweep_tick` assert in the same cycle on steps 2 and 6.
- Frame strobes and freq strobes are independent and may coincide.
- `ch12_freq_tick` spacing is 93 or 94 cycles, exactly 4 per 375 cycles. First tick is at cycle 94 after E.
- `ch3_freq_tick` spacing is 187 or 188 cycles, exactly 2 per 375 cycles.
- `seq_restart` coinciding with a frame wrap: restart wins, and no strobe is produced for that wrap.
- `master_sound_enable` falling mid-frame: strobes are 0 from the next cycle. Re-enable restarts at step 0 with a full prescale period.
- Asynchronous `reset_b` assertion clears all state and outputs immediately. Deassertion is synchronised externally.

## Configuration
- Macro: `APU_EXACT_FREQ_EN`.
- Defined: the fractional accumulators generate exact 131072 Hz and 65536 Hz strobes.
- Undefined:
  - plain counters divide by `F12_DIV` and `F3_DIV` (130723.4 Hz and 65361.7 Hz);
  - each tick fires on the cycle the counter wraps from DIV−1 to 0, so the first tick is at cycle DIV after E.
- The frame-sequencer path is identical in both builds.

## Structure
- Package `apu_timing_pkg` holds:
  - constants `PRESCALE`, `F12_NUM/DEN`, `F3_NUM/DEN`, `F12_DIV`, `F3_DIV`;
  - step-decode constants (length mask 8'b0101_0101, sweep mask 8'b0100_0100, envelope mask 8'b1000_0000).
- One sub-module, `apu_frac_divider`, instantiated twice (ch1/2 and ch3).
  - Parameters: NUM, DEN, DIV.
  - Ports: clock, reset, clear, tick.
  - `APU_EXACT_FREQ_EN` selects its implementation.

## Test plan
- Reset, then enable held for 8×24000 cycles → 4 `length_tick`, 2 `sweep_tick`, 1 `env_tick`. The first `length_tick` is exactly 24000 cycles after enable; `frame_step` is 0 at the end.
- `APU_EXACT_FREQ_EN` on, 375000 running cycles → exactly 4000 `ch12_freq_tick` and 2000 `ch3_freq_tick`. Every spacing is within {93, 94} or {187, 188} respectively.
- Macro off, 9400 running cycles → exactly 100 `ch12_freq_tick`, spacing always 94. Exactly 50 `ch3_freq_tick` in 9400 cycles.
- `seq_restart` pulsed on the wrap cycle of step 2 → no `length_tick` or `sweep_tick` for that wrap. The next `length_tick` is 24000 cycles later with S = 0.
- `master_sound_enable` dropped at prescaler 12000 of step 5, then re-enabled → no strobes while low. Restart executes step 0 after 24000 cycles.
- `reset_b` asserted asynchronously mid-frame (between edges) → all outputs 0 immediately. After release, behaviour matches the first scenario.
